// File: rtl/wvb_reader.sv
// wvb_reader: streams one waveform as header words, show-ahead sample words
// and (optionally) a trailer word over a valid/ready port.
// The optional trailer is enabled with WVB_READER_TRAILER_EN.
// P_DATA_WIDTH <= 32, P_ADR_WIDTH <= 16 and P_HDR_WIDTH == 80 are supported.
module wvb_reader #(
  parameter int P_DATA_WIDTH = 22,
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_HDR_WIDTH  = 80
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data,
  input  logic                    hdr_empty,
  output logic                    hdr_rdreq,
  input  logic [P_DATA_WIDTH-1:0] wvb_data,
  output logic                    wvb_rdreq,
  output logic                    wvb_rddone,
  output logic [31:0]             dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic                    busy,
  output logic [15:0]             wvf_count
);

  localparam int AW = P_ADR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_HDR2 = 3'd3,
    S_DATA = 3'd4,
`ifdef WVB_READER_TRAILER_EN
    S_TRL  = 3'd5,
`endif
    S_DONE = 3'd6
  } state_t;

  state_t                 state, state_nxt;
  logic [P_HDR_WIDTH-1:0] hdr_q;
  logic [AW:0]            nsamp_q;
  logic [AW:0]            remain_q;
  logic [AW-1:0]          diff;
  logic [AW:0]            nsamp_new;
  logic                   start;
  logic                   xfer;
  logic                   last_samp;

  // Sample count wraps modulo the buffer size, so stop < start is legal.
  assign diff      = hdr_data[AW-1:0] - hdr_data[2*AW-1:AW];
  assign nsamp_new = {1'b0, diff} + {{AW{1'b0}}, 1'b1};
  assign start     = (state == S_IDLE) && en && !hdr_empty;
  assign xfer      = dout_valid && dout_ready;
  assign last_samp = (remain_q == {{AW{1'b0}}, 1'b1});

  // State, latched header, sample counters and completed-waveform counter.
  // The header is captured so header words stay stable while stalled,
  // independent of what the FIFO head does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      hdr_q     <= '0;
      nsamp_q   <= '0;
      remain_q  <= '0;
      wvf_count <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        hdr_q    <= hdr_data;
        nsamp_q  <= nsamp_new;
        remain_q <= nsamp_new;
      end
      if (state == S_DATA && xfer) remain_q <= remain_q - {{AW{1'b0}}, 1'b1};
      if (state == S_DONE)         wvf_count <= wvf_count + 16'd1;
    end
  end

  // Next-state and output decode; outputs are a function of state only
  // (plus dout_ready for the pops), so they hold while stalled.
  always_comb begin
    state_nxt  = state;
    dout       = '0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    hdr_rdreq  = 1'b0;
    wvb_rdreq  = 1'b0;
    wvb_rddone = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_HDR0;
      end
      S_HDR0: begin
        dout_valid = 1'b1;
        dout       = hdr_q[79:48];
        if (xfer) state_nxt = S_HDR1;
      end
      S_HDR1: begin
        dout_valid = 1'b1;
        dout       = hdr_q[47:16];
        if (xfer) state_nxt = S_HDR2;
      end
      S_HDR2: begin
        dout_valid = 1'b1;
        dout       = {hdr_q[15:0], 16'h0000};
        if (xfer) begin
          hdr_rdreq = 1'b1;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        dout_valid = 1'b1;
        dout       = 32'(wvb_data);
        wvb_rdreq  = dout_ready;
`ifndef WVB_READER_TRAILER_EN
        dout_last  = last_samp;
`endif
        if (xfer && last_samp) begin
`ifdef WVB_READER_TRAILER_EN
          state_nxt = S_TRL;
`else
          state_nxt = S_DONE;
`endif
        end
      end
`ifdef WVB_READER_TRAILER_EN
      S_TRL: begin
        dout_valid = 1'b1;
        dout       = {16'hE0D0, 16'(nsamp_q)};
        dout_last  = 1'b1;
        if (xfer) state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        wvb_rddone = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wvb_reader.sv
// Directed bench for wvb_reader: table of waveforms plus hand sequences
// for reset mid-waveform, empty FIFO, back-to-back and en drop.
module tb_wvb_reader;

`ifdef WVB_READER_TRAILER_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        dout_ready = 1'b0;
  logic [79:0] hdr_data;
  logic        hdr_empty;
  logic        hdr_rdreq;
  logic [21:0] wvb_data;
  logic        wvb_rdreq, wvb_rddone;
  logic [31:0] dout;
  logic        dout_valid, dout_last, busy;
  logic [15:0] wvf_count;

  int checks = 0;
  int errors = 0;
  int exp_idx = 0;
  int exp_cnt = 0;

  // header FIFO model (show-ahead)
  logic [79:0] hq [0:7];
  int hp = 0;
  int hw = 0;
  assign hdr_empty = (hp == hw);
  assign hdr_data  = hq[hp % 8];
  always @(posedge clk) if (hdr_rdreq) hp <= hp + 1;

  // waveform buffer model (show-ahead)
  int widx = 0;
  function automatic logic [21:0] samp(input int i);
    return 22'(i * 37 + 5);
  endfunction
  assign wvb_data = samp(widx);
  always @(posedge clk) if (wvb_rdreq) widx <= widx + 1;

  always #5 clk = ~clk;

  wvb_reader dut (
    .clk(clk), .rst(rst), .en(en),
    .hdr_data(hdr_data), .hdr_empty(hdr_empty), .hdr_rdreq(hdr_rdreq),
    .wvb_data(wvb_data), .wvb_rdreq(wvb_rdreq), .wvb_rddone(wvb_rddone),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy), .wvf_count(wvf_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [11:0] s, input logic [11:0] e, output logic [79:0] h);
    h = {24'hA1B2C3, 32'(hw + 1) * 32'h01010101, s, e};
    hq[hw % 8] = h;
    hw = hw + 1;
  endtask

  // Drive one waveform to completion and check every transferred word.
  // Ends on the IDLE cycle following DONE, leaving dout_ready low.
  task automatic run_wave(input logic [79:0] h, input int ns, input bit stall,
                          input bit drop_en, input bit chk_lat);
    int wi = 0, hr = 0, wr = 0, cyc = 0, nw;
    bit done = 0, prev_stall = 0;
    logic [31:0] prev = '0, ew;
    nw = 3 + ns + TRL;
    while (!done && cyc < 10000) begin
      @(negedge clk);
      dout_ready = stall ? (cyc % 2 == 0) : 1'b1;
      if (drop_en && wi >= 1) en = 1'b0;
      #1;
      if (chk_lat && cyc == 0) chk("hdr0_latency", 32'(dout_valid), 1);
      if (hdr_rdreq) hr++;
      if (wvb_rdreq) wr++;
      if (prev_stall) begin
        chk("hold_dout", dout, prev);
        chk("hold_valid", 32'(dout_valid), 1);
      end
      if (dout_valid && dout_ready) begin
        if (wi == 0)           ew = h[79:48];
        else if (wi == 1)      ew = h[47:16];
        else if (wi == 2)      ew = {h[15:0], 16'h0000};
        else if (wi < 3 + ns)  ew = 32'(samp(exp_idx));
        else                   ew = {16'hE0D0, 16'(ns)};
        chk($sformatf("word%0d", wi), dout, ew);
        chk($sformatf("last%0d", wi), 32'(dout_last), 32'(wi == nw - 1));
        if (wi >= 3 && wi < 3 + ns) exp_idx++;
        wi++;
      end
      prev_stall = dout_valid && !dout_ready;
      prev = dout;
      if (wvb_rddone) done = 1;
      cyc++;
    end
    chk("wave_timeout", 32'(done), 1);
    chk("word_count", wi, nw);
    chk("hdr_rdreq_count", hr, 1);
    chk("wvb_rdreq_count", wr, ns);
    @(negedge clk);
    dout_ready = 1'b0;
    #1;
    exp_cnt++;
    chk("post_done_idle", {29'd0, busy, dout_valid, wvb_rddone}, 0);
    chk("wvf_count", 32'(wvf_count), exp_cnt);
  endtask

  typedef struct {
    logic [11:0] start;
    logic [11:0] stop;
    int          nsamp;
    bit          stall;
  } vec_t;

  initial begin
    vec_t vecs[7];
    logic [79:0] h, h2;
    int n, cyc;
    bit seen_done;

    vecs[0] = '{12'h005, 12'h00A, 6,    1'b0};
    vecs[1] = '{12'hFFE, 12'h001, 4,    1'b0};
    vecs[2] = '{12'h005, 12'h004, 4096, 1'b0};
    vecs[3] = '{12'h007, 12'h007, 1,    1'b0};
    vecs[4] = '{12'h100, 12'h103, 4,    1'b1};
    vecs[5] = '{12'h005, 12'h00A, 6,    1'b1};
    vecs[6] = '{12'hFFF, 12'h000, 2,    1'b1};
    for (int i = 0; i < 8; i++) hq[i] = '0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_flags", {25'd0, dout_valid, dout_last, busy, hdr_rdreq, wvb_rdreq, wvb_rddone, 1'b0}, 0);
    chk("rst_wvf_count", 32'(wvf_count), 0);
    @(negedge clk);
    rst = 1'b0;

    // empty FIFO keeps the reader idle
    en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("idle_empty", {28'd0, busy, dout_valid, hdr_rdreq, wvb_rdreq}, 0);
    end

    // reset after third data word: abandon waveform, no rddone
    push(12'h005, 12'h00A, h);
    dout_ready = 1'b1;
    n = 0; cyc = 0; seen_done = 0;
    while (n < 6 && cyc < 100) begin
      @(negedge clk);
      #1;
      if (dout_valid && dout_ready) begin
        n++;
        if (n > 3) exp_idx++;
      end
      if (wvb_rddone) seen_done = 1;
      cyc++;
    end
    chk("rst_mid_reach", n, 6);
    @(negedge clk);
    rst = 1'b1;
    #1;
    if (wvb_rdreq) exp_idx++;
    if (wvb_rddone) seen_done = 1;
    @(negedge clk);
    #1;
    chk("rst_mid_dout", dout, 0);
    chk("rst_mid_flags", {26'd0, dout_valid, dout_last, busy, hdr_rdreq, wvb_rdreq, wvb_rddone}, 0);
    chk("rst_mid_count", 32'(wvf_count), 0);
    rst = 1'b0;
    dout_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (wvb_rddone) seen_done = 1;
    end
    chk("rst_mid_no_rddone", 32'(seen_done), 0);
    chk("rst_mid_idle", 32'(busy), 0);

    // table of waveforms
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      push(vecs[i].start, vecs[i].stop, h);
      run_wave(h, vecs[i].nsamp, vecs[i].stall, 1'b0, 1'b1);
    end

    // back-to-back: second HDR0 valid two cycles after the rddone pulse
    @(negedge clk);
    push(12'h010, 12'h012, h);
    push(12'h020, 12'h021, h2);
    run_wave(h, 3, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("b2b_hdr0_valid", 32'(dout_valid), 1);
    chk("b2b_hdr0_word", dout, h2[79:48]);
    run_wave(h2, 2, 1'b0, 1'b0, 1'b0);

    // en dropped mid-waveform: waveform completes, then IDLE waits for en
    @(negedge clk);
    push(12'h030, 12'h034, h);
    run_wave(h, 5, 1'b1, 1'b1, 1'b1);
    push(12'h040, 12'h041, h2);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("en_low_idle", {30'd0, busy, dout_valid}, 0);
    end
    en = 1'b1;
    run_wave(h2, 2, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
